// File: rtl/usart_rx_fifo.sv
// rtl/usart_rx_fifo.sv - byte FIFO between usart_rx and its consumer with hysteretic hold
//
// Purpose: absorbs received-byte bursts while the consumer is busy. Upstream
// side is valid/ready; downstream side is first-word-visible valid/ready.
// `hold` asks the parent to throttle the sender, with hysteresis.
//
// Ports:
//   comm_clock            sole clock, rising edge
//   reset                 synchronous active-high reset
//   flush                 synchronous clear of contents (memory untouched)
//   in_data/in_valid      byte offered by upstream
//   in_ready              FIFO accepts a byte this cycle (!full)
//   out_data/out_valid    oldest stored byte / FIFO non-empty
//   out_ready             consumer takes out_data this cycle
//   level                 stored byte count, 0..DEPTH
//   empty/full            level==0 / level==DEPTH
//   hold                  throttle request with hysteresis
module usart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int HOLD_MARGIN = 4
) (
    input  logic                  comm_clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  hold
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_SET  = (DEPTH_LOG2+1)'(DEPTH - HOLD_MARGIN);
    localparam logic [DEPTH_LOG2:0] LVL_CLR  = (DEPTH_LOG2+1)'(HOLD_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  clr;
    logic                  push;
    logic                  pop;

    assign clr = reset | flush;

    assign empty     = (count == '0);
    assign full      = (count == LVL_FULL);
    assign level     = count;
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    // A clear in the same cycle discards any handshake.
    assign push = in_valid & in_ready & ~clr;
    assign pop  = out_valid & out_ready & ~clr;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage has no reset; stale words are never visible because
    // out_valid depends only on count.
    always_ff @(posedge comm_clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Evaluated on count_next so hold always matches the level
            // shown in the same cycle.
            if (count_next >= LVL_SET) begin
                hold <= 1'b1;
            end else if (count_next <= LVL_CLR) begin
                hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usart_rx_fifo.sv
// tb/tb_usart_rx_fifo.sv - directed self-checking bench for usart_rx_fifo
module tb_usart_rx_fifo;

    logic       comm_clock = 1'b0;
    logic       reset;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       hold;

    int total = 0;
    int bad   = 0;

    usart_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (4),
        .HOLD_MARGIN(4)
    ) dut (
        .comm_clock(comm_clock),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .hold      (hold)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge comm_clock);
        #1;
    endtask

    // One clock with the given handshake inputs, then idle them.
    task automatic cyc(input logic pv, input logic [7:0] d, input logic pr);
        in_valid  = pv;
        in_data   = d;
        out_ready = pr;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;

        // reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);

        // single byte through
        cyc(1'b1, 8'h41, 1'b0);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data", 32'(out_data), 32'h41);
        chk("one_level", 32'(level), 32'd1);
        chk("one_empty", 32'(empty), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("one_pop_empty", 32'(empty), 32'd1);
        chk("one_pop_level", 32'(level), 32'd0);

        // fill to full, then a held 17th byte
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("full_full", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_hold", 32'(hold), 32'd1);
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_held_level", 32'(level), 32'd16);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            if (i == 1) chk("drain_in_ready", 32'(in_ready), 32'd1);
            step();
            // AA is taken at the edge where i==1 (first cycle in_ready is back)
            if (i == 1) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("late_level", 32'(level), 32'd1);
        chk("late_data", 32'(out_data), 32'hAA);
        cyc(1'b0, 8'h00, 1'b1);
        chk("late_empty", 32'(empty), 32'd1);

        // hysteresis
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        chk("hyst_l11", 32'(level), 32'd11);
        chk("hyst_h11", 32'(hold), 32'd0);
        cyc(1'b1, 8'h2B, 1'b0);
        chk("hyst_l12", 32'(level), 32'd12);
        chk("hyst_h12", 32'(hold), 32'd1);
        for (int i = 0; i < 7; i++) begin
            chk("hyst_pop_data", 32'(out_data), 32'(8'h20 + i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("hyst_l5", 32'(level), 32'd5);
        chk("hyst_h5", 32'(hold), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("hyst_l4", 32'(level), 32'd4);
        chk("hyst_h4", 32'(hold), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("hyst_drained", 32'(empty), 32'd1);

        // continuous push+pop at level 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("stream_data", 32'(out_data), (i < 3) ? 32'(8'h70 + i) : 32'(8'h80 + i - 3));
            cyc(1'b1, 8'(8'h80 + i), 1'b1);
            chk("stream_level", 32'(level), 32'd3);
        end
        chk("stream_tail", 32'(out_data), 32'hA5);

        // climb to 12 then back to 7 so hold is set going into the flush
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'hC0, 1'b0);
        chk("pre_flush_h12", 32'(hold), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("pre_flush_l7", 32'(level), 32'd7);
        chk("pre_flush_h7", 32'(hold), 32'd1);
        flush = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_hold", 32'(hold), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b1, 8'h55, 1'b0);
        chk("post_flush_data", 32'(out_data), 32'h55);
        chk("post_flush_level", 32'(level), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_flush_empty", 32'(empty), 32'd1);

        // push into empty with out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        chk("pe_level1", 32'(level), 32'd1);
        chk("pe_data", 32'(out_data), 32'h3C);
        step();
        chk("pe_level0", 32'(level), 32'd0);
        step();
        chk("pe_still0", 32'(level), 32'd0);
        chk("pe_still_empty", 32'(empty), 32'd1);
        out_ready = 1'b0;
        cyc(1'b1, 8'h99, 1'b0);
        chk("pe_next_data", 32'(out_data), 32'h99);
        chk("pe_next_level", 32'(level), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_rx_fifo.md
Name: usart_rx_fifo

Overview:
- Byte FIFO between usart_rx and its consumer (CPU bus bridge, usart_tx, command parser); absorbs bursts so received bytes are not lost while the consumer is busy.
- Upstream side: valid/ready. Downstream side: first-word-visible valid/ready.
- Hysteretic `hold` output lets the parent throttle the sender: drive usart_rx flow control, or gate rx_ready.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 (16).
- HOLD_MARGIN, 4, hysteresis margin. `hold` sets at level >= DEPTH-HOLD_MARGIN and clears at level <= HOLD_MARGIN. Legal range: 1..DEPTH/2-1.

Ports:
- comm_clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents, same effect as reset but without touching the memory array.
- in_data  input  DATA_WIDTH  byte from upstream (usart_rx data_out).
- in_valid  input  1  upstream has a byte.
- in_ready  output  1  FIFO accepts a byte this cycle.
- out_data  output  DATA_WIDTH  oldest stored byte; meaningful only when out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes out_data this cycle.
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.
- hold  output  1  throttle request with hysteresis.

Behaviour:
- State: memory array of DEPTH words; wr_ptr and rd_ptr of DEPTH_LOG2 bits, wrapping modulo DEPTH; count register of DEPTH_LOG2+1 bits; hold register.
- Combinational outputs from registers only (no input-to-output paths):
  - in_ready = !full
  - out_valid = !empty
  - out_data = mem[rd_ptr]
  - level = count; empty = (count==0); full = (count==DEPTH)
- Push occurs at an edge when in_valid && in_ready:
  - mem[wr_ptr] <= in_data
  - wr_ptr increments
- Pop occurs at an edge when out_valid && out_ready: rd_ptr increments.
- count_next:
  - count+1 on push only
  - count-1 on pop only
  - unchanged on both or neither
- Simultaneous push and pop:
  - Allowed at any level 1..DEPTH-1; level is unchanged.
  - When full, in_ready=0, so no push happens even if a pop occurs that cycle. No same-cycle pass-through.
  - When empty, no pop is possible; a push makes out_valid=1 at the next edge.
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N (1 cycle). Throughput is 1 byte/cycle each side.
- in_valid while full: no state change. Upstream must hold the byte; the FIFO never drops or overwrites.
- out_ready while empty: ignored; no pointer movement.
- out_data/in_data changes while valid and not ready: upstream must keep in_data stable. The FIFO imposes no check.
- hold update each edge, evaluated on count_next:
  - set if count_next >= DEPTH-HOLD_MARGIN
  - else clear if count_next <= HOLD_MARGIN
  - else keep
  - hold therefore always agrees with the `level` shown in the same cycle.
- reset or flush (flush ORed with reset):
  - wr_ptr=0, rd_ptr=0, count=0, hold=0
  - outputs after the edge: in_ready=1, out_valid=0, empty=1, full=0, level=0
  - Any push or pop presented in the same cycle is discarded.
  - Memory contents need not be cleared.
- Reset mid-operation: stored bytes are lost. The first byte pushed after reset is the first byte popped.
- Pointer wrap: order is preserved across wrap. After any sequence, pops return bytes in exact push order.

Test Plan:
- Reset, then push 0x41 single cycle -> next cycle out_valid=1, out_data=0x41, level=1, empty=0. Pop -> following cycle empty=1, level=0.
- Push 16 bytes 0x00..0x0F with out_ready=0:
  - full=1, in_ready=0, level=16
  - 17th byte 0xAA held 3 cycles -> level stays 16
  - pop all 16 -> 0x00..0x0F in order
  - then 0xAA accepted once in_ready rises
- Hysteresis (DEPTH 16, margin 4):
  - fill to 11 -> hold=0; push 12th -> hold=1 the same cycle level=12
  - pop to level 5 -> hold=1; pop to 4 -> hold=0
- Continuous push and pop every cycle for 40 bytes, starting at level 3 -> level constant 3, pointers wrap twice, output stream equals input stream delayed by 3 bytes.
- flush at level 7 with in_valid=1 and out_ready=1 in the same cycle -> next cycle level=0, out_valid=0, hold=0, the pushed byte is not stored. A subsequent push of 0x55 is the next popped byte.
- Push into empty FIFO while out_ready=1 is held constantly -> the byte appears one cycle later and is popped at the following edge; level goes 0->1->0 and no extra pop occurs while empty.
